csr_trap_ctrl: RTL and testbench
================================

# csr_trap_ctrl

Machine-mode trap sequencer for the single-hart core. It detects enabled timer and external interrupts and executes `mret`, and it drives the CSR file's write port over a fixed multi-cycle sequence (mepc, mcause, mstatus). It stalls the pipeline for the length of that sequence and then issues a one-cycle PC redirect to the fetch stage. It sits between the decode/execute stage and the CSR file, and it owns the CSR write port only while busy.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `irq_timer_i` in 1: level-sensitive machine timer interrupt.
- `irq_ext_i` in 1: level-sensitive machine external interrupt.
- `mret_i` in 1: one-cycle pulse, `mret` retiring in execute.
- `pc_i` in 32: PC of the instruction to be preempted; valid whenever the FSM is IDLE.
- `csr_mstatus_i` in 32: live mstatus (0x300) from the CSR file.
- `csr_mie_i` in 32: live mie (0x304).
- `csr_mtvec_i` in 32: live mtvec (0x305).
- `csr_mepc_i` in 32: live mepc (0x341).
- `csr_wr_o` out 1: CSR write strobe.
- `csr_addr_o` out 12: CSR write address.
- `csr_wdata_o` out 32: CSR write data.
- `stall_o` out 1: freeze the pipeline.
- `redirect_o` out 1: one-cycle PC redirect strobe.
- `redirect_pc_o` out 32: redirect target.
- `busy_o` out 1: FSM not IDLE.

## Operation
- Moore FSM. The states are IDLE, T_EPC, T_CAUSE, T_STATUS, T_JUMP, R_STATUS and R_JUMP.
- Interrupt pending signals:
  - external = `irq_ext_i & csr_mie_i[11]`
  - timer = `irq_timer_i & csr_mie_i[7]`
  - An interrupt is taken only if `csr_mstatus_i[3]` (MIE) is 1.
- Interrupt priority is external (mcause 0x8000000B) over timer (0x80000007).
- IDLE behaviour:
  - If `mret_i` is 1: go to R_STATUS and latch mstatus. `mret_i` has priority over a pending interrupt in the same cycle; the interrupt is re-evaluated on return to IDLE.
  - Else if an interrupt is taken: latch `pc_i`, the cause and mstatus, then go to T_EPC.
- Trap sequence:
  - T_EPC: write 0x341 with `{pc[31:2],2'b00}`.
  - T_CAUSE: write 0x342 with the latched cause.
  - T_STATUS: write 0x300 with the latched mstatus modified as follows: bit7 (MPIE) = old bit3, bit3 = 0, bits[12:11] (MPP) = 2'b11.
  - T_JUMP: `redirect_o` = 1 with the trap target, then go to IDLE.
- Return sequence:
  - R_STATUS: write 0x300 with the latched mstatus modified as follows: bit3 = old bit7, bit7 = 1, bits[12:11] = 2'b11.
  - R_JUMP: `redirect_o` = 1 and `redirect_pc_o` = `{csr_mepc_i[31:2],2'b00}`, then go to IDLE.
- Trap target: `{csr_mtvec_i[31:2],2'b00}` by default (see Configuration).
- Interrupt inputs are ignored while busy. Because they are level-sensitive, they remain pending.
- `mret_i` is ignored while busy.
- Outputs:
  - `csr_wr_o` = 1 only in T_EPC, T_CAUSE, T_STATUS and R_STATUS.
  - In all other states, `csr_addr_o` and `csr_wdata_o` are 0.
  - `redirect_pc_o` is 0 when `redirect_o` is 0.

## Timing
- Reset values: all outputs 0, state IDLE, latched pc/cause/mstatus 0.
- `rst_n` low mid-sequence aborts immediately with no further CSR writes; partial writes already committed remain in the CSR file.
- Cycle numbering for a trap (cycle 0 = IDLE edge where the interrupt is sampled):
  - Cycle 1: T_EPC.
  - Cycle 2: T_CAUSE.
  - Cycle 3: T_STATUS.
  - Cycle 4: T_JUMP.
  - Cycle 5: IDLE.
- Each CSR write commits at the rising edge that ends its state.
- `stall_o` = `busy_o`, high for cycles 1–4 (trap) or 1–2 (mret).
- `redirect_o` is high for exactly one cycle, in the last busy cycle.
- Back-to-back events:
  - After T_JUMP the new mstatus.MIE is 0, so no immediate re-trap occurs.
  - After R_JUMP, an interrupt that is still pending is taken on the first IDLE cycle (cycle 3 after the mret).
- `csr_mtvec_i` and `csr_mepc_i` are sampled in the JUMP state itself, not latched.

## Configuration
- Macro: `CSR_TRAP_VECTORED_EN`.
- Defined:
  - If `csr_mtvec_i[1:0]` == 2'b01, the trap target = `{mtvec[31:2],2'b00} + 4*cause[3:0]` (32-bit wrap).
  - Any other mode value uses the direct base.
- Undefined: `mtvec[1:0]` is ignored and the target is always the direct base.

## Test plan
- Reset (`rst_n`=0): all outputs 0.
- Direct-mode external trap:
  - Stimulus: mstatus=0x8, mie=0x800, mtvec=0x100, `pc_i`=0x2000, `irq_ext_i`=1.
  - Required response:
    - Write 0x341←0x2000, then 0x342←0x8000000B, then 0x300←0x1880.
    - Redirect to 0x100 in cycle 4; `stall_o` high for cycles 1–4.
- Both IRQs with mie=0x880: external cause wins. Same with MIE=0 or mie=0: no writes, no stall.
- Return: mstatus=0x1880, mepc=0x2004, pulse `mret_i`.
  - Required response: write 0x300←0x1888, then redirect to 0x2004 at cycle 2.
- `mret_i` and a pending timer IRQ in the same IDLE cycle:
  - The mret sequence runs first.
  - The trap then starts in cycle 3 with mepc←the `pc_i` value present at cycle 3.
- `CSR_TRAP_VECTORED_EN` defined, mtvec=0x101, timer trap: redirect to 0x11C. Macro undefined, same stimulus: redirect to 0x100.
- `rst_n` asserted during T_CAUSE: only the mepc write is observed, outputs 0 immediately, FSM returns to IDLE.

Source files
------------

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap/mret sequencer: owns the CSR write port while busy and ends with a PC redirect.
// Optional feature: define CSR_TRAP_VECTORED_EN for vectored (mtvec mode 01) trap targets.
module csr_trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            irq_timer_i,
  input  logic            irq_ext_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] csr_mstatus_i,
  input  logic [XLEN-1:0] csr_mie_i,
  input  logic [XLEN-1:0] csr_mtvec_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  output logic            csr_wr_o,
  output logic [11:0]     csr_addr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            stall_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            busy_o
);

  localparam logic [11:0]     ADDR_MSTATUS = 12'h300;
  localparam logic [11:0]     ADDR_MEPC    = 12'h341;
  localparam logic [11:0]     ADDR_MCAUSE  = 12'h342;
  localparam logic [XLEN-1:0] CAUSE_EXT    = XLEN'(32'h8000000B);
  localparam logic [XLEN-1:0] CAUSE_TIMER  = XLEN'(32'h80000007);

  typedef enum logic [2:0] {
    IDLE,
    T_EPC,
    T_CAUSE,
    T_STATUS,
    T_JUMP,
    R_STATUS,
    R_JUMP
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [XLEN-1:0] pc_lat;
  logic [XLEN-1:0] cause_lat;
  logic [XLEN-1:0] mstatus_lat;
  logic            ext_pend;
  logic            timer_pend;
  logic            take;
  logic [XLEN-1:0] cause_sel;
  logic [XLEN-1:0] trap_pc;
  logic            unused_bits;

  // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r        = m;
    r[7]     = m[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Return: MIE <- MPIE, MPIE <- 1, MPP stays M (single-privilege core).
  function automatic logic [XLEN-1:0] ret_mstatus(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r        = m;
    r[3]     = m[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  assign ext_pend   = irq_ext_i & csr_mie_i[11];
  assign timer_pend = irq_timer_i & csr_mie_i[7];
  assign take       = csr_mstatus_i[3] & (ext_pend | timer_pend);
  assign cause_sel  = ext_pend ? CAUSE_EXT : CAUSE_TIMER;

  // mtvec is read live in T_JUMP, so software may retarget it up to that cycle.
`ifdef CSR_TRAP_VECTORED_EN
  assign trap_pc = (csr_mtvec_i[1:0] == 2'b01)
                 ? {csr_mtvec_i[XLEN-1:2], 2'b00} + {{(XLEN-6){1'b0}}, cause_lat[3:0], 2'b00}
                 : {csr_mtvec_i[XLEN-1:2], 2'b00};
`else
  assign trap_pc = {csr_mtvec_i[XLEN-1:2], 2'b00};
`endif

  assign unused_bits = ^{csr_mie_i[XLEN-1:12], csr_mie_i[10:8], csr_mie_i[6:0],
                         csr_mtvec_i[1:0], csr_mepc_i[1:0], pc_i[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Context is captured only on the IDLE cycle that launches a sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_lat      <= '0;
      cause_lat   <= '0;
      mstatus_lat <= '0;
    end else if (state == IDLE) begin
      if (mret_i) begin
        mstatus_lat <= csr_mstatus_i;
      end else if (take) begin
        pc_lat      <= {pc_i[XLEN-1:2], 2'b00};
        cause_lat   <= cause_sel;
        mstatus_lat <= csr_mstatus_i;
      end
    end
  end

  always_comb begin
    state_next    = state;
    csr_wr_o      = 1'b0;
    csr_addr_o    = '0;
    csr_wdata_o   = '0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    busy_o        = (state != IDLE);
    stall_o       = (state != IDLE);
    case (state)
      IDLE: begin
        if (mret_i) begin
          state_next = R_STATUS;
        end else if (take) begin
          state_next = T_EPC;
        end
      end
      T_EPC: begin
        csr_wr_o    = 1'b1;
        csr_addr_o  = ADDR_MEPC;
        csr_wdata_o = pc_lat;
        state_next  = T_CAUSE;
      end
      T_CAUSE: begin
        csr_wr_o    = 1'b1;
        csr_addr_o  = ADDR_MCAUSE;
        csr_wdata_o = cause_lat;
        state_next  = T_STATUS;
      end
      T_STATUS: begin
        csr_wr_o    = 1'b1;
        csr_addr_o  = ADDR_MSTATUS;
        csr_wdata_o = trap_mstatus(mstatus_lat);
        state_next  = T_JUMP;
      end
      T_JUMP: begin
        redirect_o    = 1'b1;
        redirect_pc_o = trap_pc;
        state_next    = IDLE;
      end
      R_STATUS: begin
        csr_wr_o    = 1'b1;
        csr_addr_o  = ADDR_MSTATUS;
        csr_wdata_o = ret_mstatus(mstatus_lat);
        state_next  = R_JUMP;
      end
      R_JUMP: begin
        redirect_o    = 1'b1;
        redirect_pc_o = {csr_mepc_i[XLEN-1:2], 2'b00};
        state_next    = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Testbench for csr_trap_ctrl: directed vector table, corner sequences and random traffic vs. a queue model.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        irq_timer, irq_ext, mret;
  logic [31:0] pc, mstatus, mie, mtvec, mepc;
  logic        csr_wr;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        stall, redirect, busy;
  logic [31:0] redirect_pc;

  int nvec = 0;
  int nerr = 0;

  csr_trap_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .irq_timer_i(irq_timer), .irq_ext_i(irq_ext), .mret_i(mret), .pc_i(pc),
    .csr_mstatus_i(mstatus), .csr_mie_i(mie), .csr_mtvec_i(mtvec), .csr_mepc_i(mepc),
    .csr_wr_o(csr_wr), .csr_addr_o(csr_addr), .csr_wdata_o(csr_wdata),
    .stall_o(stall), .redirect_o(redirect), .redirect_pc_o(redirect_pc), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Model: a queue of the output cycles still owed by the current sequence.
  typedef struct { int kind; logic [11:0] a; logic [31:0] d; } exp_t;  // kind 0 write, 1 trap jump, 2 ret jump
  exp_t mq[$];

  typedef struct { logic [11:0] a; logic [31:0] d; } wr_t;
  wr_t         wlog[$];
  int          nred, nstall;
  logic [31:0] last_rpc;

  typedef struct {
    logic [31:0] ms, mie, mtvec, mepc, pc;
    logic        it, ie, mr;
    int          nw;
    logic [11:0] wa[3];
    logic [31:0] wd[3];
    logic        red;
    logic [31:0] rpc;
    int          ns;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_trap_ms(input logic [31:0] m);
    return (m & ~32'h1888) | 32'h1800 | ((m & 32'h8) << 4);
  endfunction

  function automatic logic [31:0] m_ret_ms(input logic [31:0] m);
    return (m & ~32'h1888) | 32'h1880 | ((m & 32'h80) >> 4);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] tv, input logic [31:0] cause);
    logic [31:0] t;
    t = tv & ~32'h3;
`ifdef CSR_TRAP_VECTORED_EN
    if (tv % 4 == 1) t = t + 4 * (cause % 16);
`endif
    return t;
  endfunction

  task automatic clear_log();
    wlog.delete();
    nred = 0;
    nstall = 0;
    last_rpc = 0;
  endtask

  // One clock: compare outputs in the low phase, advance the model, wait for the next falling edge.
  task automatic tick();
    logic        e_wr, e_red, e_busy;
    logic [11:0] e_a;
    logic [31:0] e_d, e_rpc, cause;
    exp_t        en;
    #1;
    e_wr = 0; e_red = 0; e_busy = 0; e_a = 0; e_d = 0; e_rpc = 0; cause = 0;
    if (!rst_n) begin
      mq.delete();
    end else if (mq.size() > 0) begin
      en = mq.pop_front();
      e_busy = 1;
      if (en.kind == 0) begin
        e_wr = 1; e_a = en.a; e_d = en.d;
      end else if (en.kind == 1) begin
        e_red = 1; e_rpc = m_target(mtvec, en.d);
      end else begin
        e_red = 1; e_rpc = mepc & ~32'h3;
      end
    end else if (mret) begin
      mq.push_back('{0, 12'h300, m_ret_ms(mstatus)});
      mq.push_back('{2, 12'h000, 32'h0});
    end else begin
      if (mstatus[3] && irq_ext && mie[11]) cause = 32'h8000000B;
      else if (mstatus[3] && irq_timer && mie[7]) cause = 32'h80000007;
      if (cause != 0) begin
        mq.push_back('{0, 12'h341, pc & ~32'h3});
        mq.push_back('{0, 12'h342, cause});
        mq.push_back('{0, 12'h300, m_trap_ms(mstatus)});
        mq.push_back('{1, 12'h000, cause});
      end
    end
    check("csr_wr", 32'(csr_wr), 32'(e_wr));
    check("csr_addr", 32'(csr_addr), 32'(e_a));
    check("csr_wdata", csr_wdata, e_d);
    check("redirect", 32'(redirect), 32'(e_red));
    check("redirect_pc", redirect_pc, e_rpc);
    check("busy", 32'(busy), 32'(e_busy));
    check("stall", 32'(stall), 32'(e_busy));
    if (csr_wr) wlog.push_back('{csr_addr, csr_wdata});
    if (redirect) begin nred++; last_rpc = redirect_pc; end
    if (stall) nstall++;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr"}, 32'(csr_wr), 0);
    check({tag, "_addr"}, 32'(csr_addr), 0);
    check({tag, "_wdata"}, csr_wdata, 0);
    check({tag, "_stall"}, 32'(stall), 0);
    check({tag, "_redirect"}, 32'(redirect), 0);
    check({tag, "_rpc"}, redirect_pc, 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic add(input logic [31:0] ms, mi, tv, ep, p, input logic it, ie, mr, input int nw,
                     input logic [11:0] a0, input logic [31:0] d0, input logic [11:0] a1,
                     input logic [31:0] d1, input logic [11:0] a2, input logic [31:0] d2,
                     input logic red, input logic [31:0] rpc, input int ns);
    vec_t v;
    v.ms = ms; v.mie = mi; v.mtvec = tv; v.mepc = ep; v.pc = p;
    v.it = it; v.ie = ie; v.mr = mr; v.nw = nw;
    v.wa[0] = a0; v.wd[0] = d0; v.wa[1] = a1; v.wd[1] = d1; v.wa[2] = a2; v.wd[2] = d2;
    v.red = red; v.rpc = rpc; v.ns = ns;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] vec_rpc;
`ifdef CSR_TRAP_VECTORED_EN
    vec_rpc = 32'h11C;
`else
    vec_rpc = 32'h100;
`endif
    //  mstatus  mie      mtvec    mepc     pc       it ie mr nw  writes ...                                                           red rpc      stall
    add(32'h8,    32'h800, 32'h100, 32'h0,    32'h2000, 0, 1, 0, 3, 12'h341, 32'h2000, 12'h342, 32'h8000000B, 12'h300, 32'h1880, 1, 32'h100,  4);
    add(32'h8,    32'h880, 32'h100, 32'h0,    32'h2000, 1, 1, 0, 3, 12'h341, 32'h2000, 12'h342, 32'h8000000B, 12'h300, 32'h1880, 1, 32'h100,  4);
    add(32'h0,    32'h880, 32'h100, 32'h0,    32'h2000, 1, 1, 0, 0, 12'h0,   32'h0,    12'h0,   32'h0,        12'h0,   32'h0,    0, 32'h0,    0);
    add(32'h8,    32'h0,   32'h100, 32'h0,    32'h2000, 1, 1, 0, 0, 12'h0,   32'h0,    12'h0,   32'h0,        12'h0,   32'h0,    0, 32'h0,    0);
    add(32'h8,    32'h80,  32'h100, 32'h0,    32'h2000, 0, 1, 0, 0, 12'h0,   32'h0,    12'h0,   32'h0,        12'h0,   32'h0,    0, 32'h0,    0);
    add(32'h8,    32'h80,  32'h101, 32'h0,    32'h3006, 1, 0, 0, 3, 12'h341, 32'h3004, 12'h342, 32'h80000007, 12'h300, 32'h1880, 1, vec_rpc,  4);
    add(32'h1880, 32'h0,   32'h100, 32'h2004, 32'h0,    0, 0, 1, 1, 12'h300, 32'h1888, 12'h0,   32'h0,        12'h0,   32'h0,    1, 32'h2004, 2);
    add(32'h0008, 32'h0,   32'h100, 32'h2007, 32'h0,    0, 0, 1, 1, 12'h300, 32'h1880, 12'h0,   32'h0,        12'h0,   32'h0,    1, 32'h2004, 2);

    rst_n = 0; irq_timer = 0; irq_ext = 0; mret = 0;
    pc = 0; mstatus = 0; mie = 0; mtvec = 0; mepc = 0;
    clear_log();
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      clear_log();
      mstatus = tbl[i].ms; mie = tbl[i].mie; mtvec = tbl[i].mtvec; mepc = tbl[i].mepc; pc = tbl[i].pc;
      irq_timer = tbl[i].it; irq_ext = tbl[i].ie; mret = tbl[i].mr;
      tick();
      irq_timer = 0; irq_ext = 0; mret = 0;
      repeat (6) tick();
      check($sformatf("v%0d_nwrites", i), 32'(wlog.size()), 32'(tbl[i].nw));
      for (int k = 0; k < tbl[i].nw && k < wlog.size(); k++) begin
        check($sformatf("v%0d_waddr%0d", i, k), 32'(wlog[k].a), 32'(tbl[i].wa[k]));
        check($sformatf("v%0d_wdata%0d", i, k), wlog[k].d, tbl[i].wd[k]);
      end
      check($sformatf("v%0d_nredirect", i), 32'(nred), 32'(tbl[i].red));
      check($sformatf("v%0d_rpc", i), last_rpc, tbl[i].rpc);
      check($sformatf("v%0d_nstall", i), 32'(nstall), 32'(tbl[i].ns));
    end

    // mret and a pending timer interrupt in the same IDLE cycle.
    clear_log();
    mstatus = 32'h1888; mie = 32'h80; mtvec = 32'h200; mepc = 32'h5000; pc = 32'h4000;
    irq_timer = 1; mret = 1;
    tick();
    mret = 0;
    for (int c = 1; c <= 3; c++) begin
      pc = 32'h4000 + 4 * c;
      tick();
    end
    irq_timer = 0;
    repeat (5) tick();
    check("mret_irq_nwrites", 32'(wlog.size()), 4);
    if (wlog.size() == 4) begin
      check("mret_irq_w0_addr", 32'(wlog[0].a), 32'h300);
      check("mret_irq_w0_data", wlog[0].d, 32'h1888);
      check("mret_irq_w1_addr", 32'(wlog[1].a), 32'h341);
      check("mret_irq_mepc", wlog[1].d, 32'h400C);
      check("mret_irq_cause", wlog[2].d, 32'h80000007);
      check("mret_irq_mstatus", wlog[3].d, 32'h1880);
    end
    check("mret_irq_nredirect", 32'(nred), 2);
    check("mret_irq_last_rpc", last_rpc, 32'h200);
    check("mret_irq_nstall", 32'(nstall), 6);

    // Reset asserted while the sequencer sits in T_CAUSE.
    clear_log();
    mstatus = 32'h8; mie = 32'h800; mtvec = 32'h100; pc = 32'h6000; irq_ext = 1;
    tick();
    irq_ext = 0;
    tick();
    rst_n = 0;
    #2;
    check_all_zero("abort");
    mq.delete();
    @(negedge clk);
    rst_n = 1;
    repeat (3) tick();
    check("abort_nwrites", 32'(wlog.size()), 1);
    if (wlog.size() == 1) begin
      check("abort_w0_addr", 32'(wlog[0].a), 32'h341);
      check("abort_w0_data", wlog[0].d, 32'h6000);
    end
    check("abort_nredirect", 32'(nred), 0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      irq_timer = ($urandom_range(0, 9) < 3);
      irq_ext   = ($urandom_range(0, 9) < 3);
      mret      = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 4))
        0: mie = 32'h0;
        1: mie = 32'h80;
        2: mie = 32'h800;
        3: mie = 32'h880;
        default: mie = $urandom;
      endcase
      mstatus = $urandom;
      mtvec   = $urandom;
      if ($urandom_range(0, 1) == 1) mtvec = (mtvec & ~32'h3) | 32'h1;
      mepc    = $urandom;
      pc      = $urandom;
      tick();
    end
    rst_n = 1; irq_timer = 0; irq_ext = 0; mret = 0;
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
